// File: rtl/riscv_cfg_discovery_regs.sv
// riscv_cfg_discovery_regs
//
// Memory-mapped configuration discovery block. Software reads the elaborated
// core identity, XLEN, extension flags, core count and cache sizes from
// read-only registers; a scratch register, a small control register and a
// free-running 64-bit cycle counter complete the map.
//
// Register map (byte offsets, 32-bit words):
//   0x00 ID       RO  CORE_ID
//   0x04 FEAT     RO  {23'b0, HAS_M_EXT, XLEN[7:0]}
//   0x08 CORES    RO  {24'b0, NUM_CORES[7:0]}
//   0x0C L1       RO  {L1D_SIZE_KB[15:0], L1I_SIZE_KB[15:0]}
//   0x10 L2       RO  {16'b0, L2_SIZE_KB[15:0]}
//   0x14 SCRATCH  RW  32 bits, byte strobed
//   0x18 CTRL     RW  bits [7:0], only wstrb[0] takes effect
//   0x1C CYC_LO   RO  counter low word; latches high word into the shadow
//   0x20 CYC_HI   RO  shadow captured by the last CYC_LO read
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i / req_ready_o request handshake
//   req_addr_i, req_write_i, req_wdata_i, req_wstrb_i  request payload
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_rdata_o, rsp_err_o    response payload
//   ctrl_o                    live CTRL register contents
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. Valid never depends on ready. Once rsp_valid_o rises, the response
// payload stays constant until it transfers. req_ready_o is high whenever the
// single response slot is empty or is being drained this cycle, so a new
// request can replace a consumed response on the same edge.
module riscv_cfg_discovery_regs #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter logic [31:0] CORE_ID     = 32'h5256_3332,
    parameter int unsigned XLEN        = 32,
    parameter bit          HAS_M_EXT   = 1'b1,
    parameter int unsigned NUM_CORES   = 1,
    parameter int unsigned L1I_SIZE_KB = 16,
    parameter int unsigned L1D_SIZE_KB = 16,
    parameter int unsigned L2_SIZE_KB  = 256,
    parameter logic [7:0]  CTRL_RESET  = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [7:0]            ctrl_o
);

    localparam logic [31:0] FEAT_VAL  = {23'b0, HAS_M_EXT, 8'(XLEN)};
    localparam logic [31:0] CORES_VAL = {24'b0, 8'(NUM_CORES)};
    localparam logic [31:0] L1_VAL    = {16'(L1D_SIZE_KB), 16'(L1I_SIZE_KB)};
    localparam logic [31:0] L2_VAL    = {16'b0, 16'(L2_SIZE_KB)};

    // Highest valid word offset.
    localparam logic [ADDR_WIDTH-1:0] OFF_LAST = ADDR_WIDTH'(32'h20);

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] scratch_q;
    logic [7:0]  ctrl_q;
    logic [63:0] cyc_q;
    logic [31:0] cyc_hi_q;

    logic        accept;
    logic [31:0] dec_rdata;
    logic        dec_err;
    logic        dec_ro;
    logic        sel_scratch;
    logic        sel_ctrl;
    logic        sel_cyc_lo;

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign ctrl_o      = ctrl_q;

    // Address decode for the request currently on the bus. Errors and writes
    // return zero data; an erroring access must not touch any state, so the
    // select strobes are only honoured when dec_err is clear.
    always_comb begin
        dec_rdata   = '0;
        dec_err     = 1'b0;
        dec_ro      = 1'b1;
        sel_scratch = 1'b0;
        sel_ctrl    = 1'b0;
        sel_cyc_lo  = 1'b0;
        if ((req_addr_i[1:0] != 2'b00) || (req_addr_i > OFF_LAST)) begin
            dec_err = 1'b1;
        end else begin
            case (req_addr_i[5:2])
                4'd0: dec_rdata = CORE_ID;
                4'd1: dec_rdata = FEAT_VAL;
                4'd2: dec_rdata = CORES_VAL;
                4'd3: dec_rdata = L1_VAL;
                4'd4: dec_rdata = L2_VAL;
                4'd5: begin
                    dec_rdata   = scratch_q;
                    dec_ro      = 1'b0;
                    sel_scratch = 1'b1;
                end
                4'd6: begin
                    dec_rdata = {24'b0, ctrl_q};
                    dec_ro    = 1'b0;
                    sel_ctrl  = 1'b1;
                end
                4'd7: begin
                    dec_rdata  = cyc_q[31:0];
                    sel_cyc_lo = 1'b1;
                end
                4'd8:    dec_rdata = cyc_hi_q;
                default: dec_err   = 1'b1;
            endcase
            if (req_write_i && dec_ro) begin
                dec_err = 1'b1;
            end
        end
        if (dec_err || req_write_i) begin
            dec_rdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            scratch_q   <= '0;
            ctrl_q      <= CTRL_RESET;
            cyc_q       <= '0;
            cyc_hi_q    <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (accept) begin
                // Loads even when the previous response drains on this edge,
                // keeping rsp_valid_q high for back-to-back traffic.
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= dec_rdata;
                rsp_err_q   <= dec_err;
                if (!dec_err) begin
                    if (req_write_i) begin
                        if (sel_scratch) begin
                            for (int b = 0; b < 4; b++) begin
                                if (req_wstrb_i[b]) begin
                                    scratch_q[8*b +: 8] <= req_wdata_i[8*b +: 8];
                                end
                            end
                        end
                        if (sel_ctrl && req_wstrb_i[0]) begin
                            ctrl_q <= req_wdata_i[7:0];
                        end
                    end else if (sel_cyc_lo) begin
                        // Capture the high half alongside the low half so
                        // a following CYC_HI read is coherent.
                        cyc_hi_q <= cyc_q[63:32];
                    end
                end
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

endmodule
